// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the async FIFO write/read controllers.
//   ADDR_W  : default RAM address width
//   PTR_W   : pointer width (one extra wrap bit above the address)
//   DEPTH   : number of RAM entries
//   bin2gray / gray2bin : pointer code conversions, written on a 32-bit
//   carrier so any pointer width up to 32 can use them via size casts.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDR_W = 4;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Ports:
//   clk   : destination-domain clock
//   rst_n : synchronous active-low reset, clears both stages
//   d     : asynchronous input bus (must change at most one bit at a time)
//   q     : synchronised output, two clk cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff
    import fifo_pkg::*;
#(
    parameter int WIDTH = PTR_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // NOTE: reset is sampled on the clock edge (no rst_n in the sensitivity
    // list), and sequential state uses non-blocking assignments so both
    // stages shift on the same edge without ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d;
            stage2_q <= stage1_q;
        end
    end

    assign q = stage2_q;

endmodule

// File: rtl/fifo_wr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_arb_ctrl
// Write-side controller of the async FIFO. Arbitrates the single RAM write
// port between NUM_REQ requesters (round robin), owns the binary/Gray write
// pointer, synchronises the read Gray pointer and produces full, almost_full
// and a conservative fill level.
// Ports:
//   clk, rst_n      : write clock, synchronous active-low reset
//   req             : per-requester level request, held until granted
//   gnt             : one-hot grant, a write happens this cycle
//   wr_en, wr_addr  : RAM write enable and address
//   rd_gray_async   : read-domain Gray pointer (asynchronous)
//   wr_gray         : registered Gray write pointer for the read domain
//   full            : registered full flag
//   almost_full     : registered, free slots <= AF_THRESH
//   wr_level        : registered fill count (may over-report, never under)
// -----------------------------------------------------------------------------
module fifo_wr_arb_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int NUM_REQ    = 4,
    parameter int AF_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH:0]   rd_gray_async,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level
);

    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
    localparam int IDX_W      = $clog2(NUM_REQ);

    // Full when the write pointer equals the read pointer with the top two
    // Gray bits inverted (same address, opposite wrap).
    localparam logic [PTR_WIDTH-1:0] FULL_MASK = PTR_WIDTH'(3) << (PTR_WIDTH - 2);

    logic [PTR_WIDTH-1:0] rq2;
    logic [PTR_WIDTH-1:0] rd_bin;

    logic [IDX_W-1:0]     last_q,    last_d;
    logic [PTR_WIDTH-1:0] wr_bin_q,  wr_bin_d;
    logic [PTR_WIDTH-1:0] wr_gray_q, wr_gray_d;
    logic [PTR_WIDTH-1:0] level_q,   level_d;
    logic                 full_q,    full_d;
    logic                 af_q,      af_d;

    sync_2ff #(
        .WIDTH (PTR_WIDTH)
    ) u_rd_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rd_gray_async),
        .q     (rq2)
    );

    // Round-robin search from last+1, wrapping. Grant is suppressed while
    // full and during reset so no write can slip into the reset cycle.
    always_comb begin
        int unsigned idx;
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise synthesis infers latches.
        gnt    = '0;
        last_d = last_q;
        idx    = 0;
        if (rst_n && !full_q && (|req)) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (int'(last_q) + k) % NUM_REQ;
                if ((gnt == '0) && req[idx]) begin
                    gnt[idx] = 1'b1;
                    last_d   = IDX_W'(idx);
                end
            end
        end
    end

    assign wr_en   = |gnt;
    assign wr_addr = wr_bin_q[ADDR_WIDTH-1:0];

    // Flags are computed from the post-write pointer and the current rq2,
    // so a write coinciding with a read-pointer update sees both new values.
    always_comb begin
        wr_bin_d  = wr_bin_q + PTR_WIDTH'(wr_en);
        wr_gray_d = PTR_WIDTH'(bin2gray(32'(wr_bin_d)));
        rd_bin    = PTR_WIDTH'(gray2bin(32'(rq2)));
        full_d    = (wr_gray_d == (rq2 ^ FULL_MASK));
        level_d   = wr_bin_d - rd_bin;
        af_d      = (FIFO_DEPTH - int'(level_d)) <= AF_THRESH;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q    <= IDX_W'(NUM_REQ - 1);
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
        end else begin
            last_q    <= last_d;
            wr_bin_q  <= wr_bin_d;
            wr_gray_q <= wr_gray_d;
            level_q   <= level_d;
            full_q    <= full_d;
            af_q      <= af_d;
        end
    end

    assign wr_gray     = wr_gray_q;
    assign full        = full_q;
    assign almost_full = af_q;
    assign wr_level    = level_q;

endmodule

// File: tb/tb_fifo_wr_arb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arb_ctrl
// Self-checking bench: directed scenarios followed by randomized requests and
// reader activity, all compared against a pointer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arb_ctrl;
    import fifo_pkg::*;

    localparam int AW  = 4;
    localparam int NR  = 4;
    localparam int AFT = 2;
    localparam int PW  = AW + 1;
    localparam int DEP = 1 << AW;
    localparam int MOD = 1 << PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NR-1:0] req;
    logic [NR-1:0] gnt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] rd_gray_async;
    logic [PW-1:0] wr_gray;
    logic          full;
    logic          almost_full;
    logic [PW-1:0] wr_level;

    always #5 clk = ~clk;

    fifo_wr_arb_ctrl #(
        .ADDR_WIDTH (AW),
        .NUM_REQ    (NR),
        .AF_THRESH  (AFT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .gnt           (gnt),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .rd_gray_async (rd_gray_async),
        .wr_gray       (wr_gray),
        .full          (full),
        .almost_full   (almost_full),
        .wr_level      (wr_level)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: write count, read pointer as seen through the
    // synchroniser (a delay line), and the last granted requester.
    int            m_wr;
    int            m_last;
    int            m_level;
    bit            m_full;
    bit            m_af;
    int            hist[$];
    logic [NR-1:0] m_gnt;
    int            rd_ptr;
    bit            prev_write;
    logic [PW-1:0] prev_gray;
    int            grants_seen;

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_reset();
        m_wr       = 0;
        m_last     = NR - 1;
        m_level    = 0;
        m_full     = 1'b0;
        m_af       = 1'b0;
        hist       = '{0, 0};
        prev_write = 1'b0;
    endtask

    // One clock cycle: called just after a negedge. Drives the read pointer,
    // compares all outputs mid-cycle, then advances the model on posedge.
    task automatic tick(input bit use_want = 1'b0, input logic [NR-1:0] want = '0);
        int gidx;
        rd_gray_async = PW'(gray_of(rd_ptr));
        #1;
        m_gnt = '0;
        gidx  = -1;
        if (rst_n && !m_full) begin
            for (int k = 1; k <= NR; k++) begin
                int i;
                i = (m_last + k) % NR;
                if (gidx < 0 && req[i]) gidx = i;
            end
        end
        if (gidx >= 0) m_gnt[gidx] = 1'b1;

        if (prev_write) check("gray_hamming", $countones(wr_gray ^ prev_gray), 1);
        check("gnt", int'(gnt), int'(m_gnt));
        check("wr_en", int'(wr_en), int'(gidx >= 0));
        check("wr_addr", int'(wr_addr), m_wr % DEP);
        check("wr_gray", int'(wr_gray), gray_of(m_wr));
        check("full", int'(full), int'(m_full));
        check("almost_full", int'(almost_full), int'(m_af));
        check("wr_level", int'(wr_level), m_level);
        check("level_bound", int'(int'(wr_level) <= DEP), 1);
        if (use_want) check("gnt_directed", int'(gnt), int'(want));
        if (wr_en) grants_seen++;
        prev_gray = wr_gray;

        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            if (gidx >= 0) begin
                m_wr   = (m_wr + 1) % MOD;
                m_last = gidx;
            end
            // Flags use the read pointer as it stood before this edge.
            m_level = (m_wr - hist[0] + MOD) % MOD;
            m_full  = (m_level == DEP);
            m_af    = (DEP - m_level) <= AFT;
            hist.push_back(rd_ptr);
            void'(hist.pop_front());
            prev_write = (gidx >= 0);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        rd_ptr = 0;
        tick(1'b1, '0);
        rst_n  = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rate;
        int avail;

        rst_n         = 1'b0;
        req           = '0;
        rd_ptr        = 0;
        rd_gray_async = '0;
        grants_seen   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Reset state
        check("rst_wr_gray", int'(wr_gray), 0);
        check("rst_full", int'(full), 0);
        check("rst_af", int'(almost_full), 0);
        check("rst_level", int'(wr_level), 0);
        check("rst_wr_addr", int'(wr_addr), 0);

        // 1: fill with all requesters active, reader idle
        req = '1;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, NR'(1 << (i % NR)));
            if (i == 12) check("t1_af_before", int'(almost_full), 0);
            if (i == 13) check("t1_af_after", int'(almost_full), 1);
        end
        check("t1_full", int'(full), 1);
        tick(1'b1, '0);
        tick(1'b1, '0);

        // 2: reader frees 4 slots; full clears 3 cycles later
        rd_ptr = 4;
        n = 0;
        while (full && n < 8) begin
            tick();
            n++;
        end
        check("t2_full_latency", n, 3);
        check("t2_level", int'(wr_level), 12);
        check("t2_af", int'(almost_full), 0);
        grants_seen = 0;
        n = 0;
        while (!full && n < 10) begin
            tick();
            n++;
        end
        check("t2_grants", grants_seen, 4);
        check("t2_full_again", int'(full), 1);

        // 3: wrap-around with a reader that follows immediately
        rd_ptr      = m_wr;
        grants_seen = 0;
        n = 0;
        while (grants_seen < 40 && n < 200) begin
            tick();
            rd_ptr = m_wr;
            n++;
            if (n > 3) check("t3_no_full", int'(full), 0);
        end
        check("t3_writes", grants_seen, 40);

        // 4: fairness between requesters 0 and 2
        apply_reset();
        req = 4'b0101;
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, (i % 2) ? 4'b0100 : 4'b0001);
            rd_ptr = m_wr;
        end

        // 5: one-cycle reset in the middle of a burst
        apply_reset();
        req = '1;
        for (int i = 0; i < 6; i++) tick();
        rst_n  = 1'b0;
        rd_ptr = 0;
        tick(1'b1, '0);
        rst_n = 1'b1;
        check("t5_wr_gray", int'(wr_gray), 0);
        check("t5_level", int'(wr_level), 0);
        check("t5_full", int'(full), 0);
        check("t5_wr_addr", int'(wr_addr), 0);
        tick(1'b1, 4'b0001);

        // 6: requester 2 joins exactly when full rises
        apply_reset();
        req = 4'b0001;
        n = 0;
        while (!full && n < 40) begin
            tick();
            n++;
        end
        check("t6_full", int'(full), 1);
        req = 4'b0101;
        for (int i = 0; i < 3; i++) tick(1'b1, '0);
        rd_ptr = 1;
        n = 0;
        while (full && n < 8) begin
            tick(1'b1, '0);
            n++;
        end
        check("t6_full_cleared", int'(full), 0);
        tick(1'b1, 4'b0100);

        // Randomized phase
        apply_reset();
        req  = '0;
        rate = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ((cyc % 256) == 0) rate = $urandom_range(0, 4);
            if ($urandom_range(0, 299) == 0) begin
                apply_reset();
            end else begin
                tick();
                req = (req & ~m_gnt) | NR'($urandom_range(0, 15) & $urandom_range(0, 15));
                avail = (m_wr - rd_ptr + MOD) % MOD;
                if (avail > 0 && $urandom_range(0, 3) < rate) rd_ptr = (rd_ptr + 1) % MOD;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
